st_colour_bbox: RTL and testbench

- Avalon-ST video stage placed directly downstream of the camera packetiser. It consumes control packets (ID 15) and video packets (ID 0) whose pixels are 24-bit {B,G,R}.
- All beats pass through unchanged, except that matching pixels are optionally recoloured.
- Per video frame it counts pixels inside a programmable RGB threshold window and tracks their bounding box. The result is published once per frame for the navigation processor.

---
 rtl/st_colour_bbox.sv | 218 +++++++++++++++++++++
 tb/tb_st_colour_bbox.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_colour_bbox.sv
// Avalon-ST pass-through stage: counts pixels inside an RGB threshold window per
// video frame, tracks their bounding box and optionally recolours them.
module st_colour_bbox #(
    parameter int          VIDEO_W    = 800,
    parameter int          VIDEO_H    = 480,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [23:0] HILITE     = 24'h00FF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [23:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    input  logic [7:0]  thr_r_min,
    input  logic [7:0]  thr_g_max,
    input  logic [7:0]  thr_b_max,
    input  logic        hilite_en,
    output logic [10:0] bbox_x_min,
    output logic [10:0] bbox_x_max,
    output logic [9:0]  bbox_y_min,
    output logic [9:0]  bbox_y_max,
    output logic [18:0] match_count,
    output logic        result_valid
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [10:0] X_LAST  = 11'(VIDEO_W - 1);
    localparam logic [9:0]  Y_LAST  = 10'(VIDEO_H - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, VIDEO = 2'd1, OTHER = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [25:0]   mem_q [FIFO_DEPTH];
    logic [25:0]   head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          in_ready_q, in_ready_d, pre_ready_q, pre_ready_d, ovf_q, ovf_d;
    logic          full, wr, rd, pixel_match;
    logic [23:0]   wr_data;
    logic [10:0]   x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]    y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [18:0]   cnt_q, cnt_d;
    logic          frame_end_q, frame_end_d;
    logic [10:0]   res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d;
    logic [9:0]    res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d;
    logic [18:0]   res_cnt_q, res_cnt_d;
    logic          res_valid_q, res_valid_d;

    assign full        = (count_q == DEPTH_C);
    assign wr          = in_valid & ~full;
    assign rd          = pre_ready_q & (count_q != '0);
    assign pixel_match = (in_data[7:0] >= thr_r_min) & (in_data[15:8] <= thr_g_max)
                       & (in_data[23:16] <= thr_b_max);

    always_comb begin
        wr_ptr_d    = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        // Two free entries cover the beat already in flight under readyLatency=1.
        in_ready_d  = (count_d <= DEPTH_C - (AW + 1)'(2));
        pre_ready_d = out_ready;
        ovf_d       = ovf_q | (in_valid & full);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        cnt_d       = cnt_q;
        frame_end_d = 1'b0;
        wr_data     = in_data;
        if (wr) begin
            if (in_sop) begin
                // Any sop re-decodes a header, abandoning a packet in progress.
                if (in_data[3:0] == 4'd0) begin
                    state_d = VIDEO;
                    x_d     = '0;
                    y_d     = '0;
                    xmin_d  = X_LAST;
                    xmax_d  = '0;
                    ymin_d  = Y_LAST;
                    ymax_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = OTHER;
                end
            end else begin
                case (state_q)
                    VIDEO: begin
                        if (pixel_match) begin
                            if (x_q < xmin_q) xmin_d = x_q;
                            if (x_q > xmax_q) xmax_d = x_q;
                            if (y_q < ymin_q) ymin_d = y_q;
                            if (y_q > ymax_q) ymax_d = y_q;
                            if (cnt_q != '1) cnt_d = cnt_q + 19'd1;
                            if (hilite_en) wr_data = HILITE;
                        end
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q != Y_LAST) y_d = y_q + 10'd1;
                        end else begin
                            x_d = x_q + 11'd1;
                        end
                        if (in_eop) begin
                            state_d     = IDLE;
                            frame_end_d = 1'b1;
                        end
                    end
                    OTHER: if (in_eop) state_d = IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        res_xmin_d  = res_xmin_q;
        res_xmax_d  = res_xmax_q;
        res_ymin_d  = res_ymin_q;
        res_ymax_d  = res_ymax_q;
        res_cnt_d   = res_cnt_q;
        res_valid_d = frame_end_q;
        if (frame_end_q) begin
            if (cnt_q == '0) begin
                res_xmin_d = '0;
                res_xmax_d = '0;
                res_ymin_d = '0;
                res_ymax_d = '0;
                res_cnt_d  = '0;
            end else begin
                res_xmin_d = xmin_q;
                res_xmax_d = xmax_q;
                res_ymin_d = ymin_q;
                res_ymax_d = ymax_q;
                res_cnt_d  = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            pre_ready_q <= 1'b0;
            ovf_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            cnt_q       <= '0;
            frame_end_q <= 1'b0;
            res_xmin_q  <= '0;
            res_xmax_q  <= '0;
            res_ymin_q  <= '0;
            res_ymax_q  <= '0;
            res_cnt_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            pre_ready_q <= pre_ready_d;
            ovf_q       <= ovf_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            cnt_q       <= cnt_d;
            frame_end_q <= frame_end_d;
            res_xmin_q  <= res_xmin_d;
            res_xmax_q  <= res_xmax_d;
            res_ymin_q  <= res_ymin_d;
            res_ymax_q  <= res_ymax_d;
            res_cnt_q   <= res_cnt_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {in_sop, in_eop, wr_data};
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_valid    = rd;
    assign out_data     = rd ? head[23:0] : 24'd0;
    assign out_sop      = rd & head[25];
    assign out_eop      = rd & head[24];
    assign in_ready     = in_ready_q;
    assign bbox_x_min   = res_xmin_q;
    assign bbox_x_max   = res_xmax_q;
    assign bbox_y_min   = res_ymin_q;
    assign bbox_y_max   = res_ymax_q;
    assign match_count  = res_cnt_q;
    assign result_valid = res_valid_q;

endmodule

// File: tb/tb_st_colour_bbox.sv
// Randomised bench for st_colour_bbox: a frame-level reference model fills
// scoreboards of expected beats and results; a monitor drains them.
module tb_st_colour_bbox;
    localparam int          W  = 20;
    localparam int          H  = 12;
    localparam int          D  = 4;
    localparam logic [23:0] HL = 24'h00FF00;
    localparam int          CMAX = 524287;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready;
    logic [7:0]  thr_r_min = 8'd128, thr_g_max = 8'd64, thr_b_max = 8'd64;
    logic        hilite_en = 1'b0;
    logic [10:0] bbox_x_min, bbox_x_max;
    logic [9:0]  bbox_y_min, bbox_y_max;
    logic [18:0] match_count;
    logic        result_valid;

    always #5 clk = ~clk;

    st_colour_bbox #(.VIDEO_W(W), .VIDEO_H(H), .FIFO_DEPTH(D), .HILITE(HL)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready),
        .thr_r_min(thr_r_min), .thr_g_max(thr_g_max), .thr_b_max(thr_b_max),
        .hilite_en(hilite_en),
        .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
        .match_count(match_count), .result_valid(result_valid)
    );

    typedef struct packed {logic sop; logic eop; logic [23:0] d;} beat_t;
    typedef struct packed {
        logic [10:0] xmin; logic [10:0] xmax; logic [9:0] ymin; logic [9:0] ymax; logic [18:0] cnt;
    } res_t;

    beat_t stim_q[$];
    beat_t exp_q[$];
    res_t  res_q[$];

    int checks = 0, fails = 0;
    int cyc = 0, out_total = 0, hl_total = 0, bubbles = 0, rdy_viol = 0, last_eop_cyc = 0;
    bit tight = 1'b0, bp_mode = 1'b0, last_rdy = 1'b0;

    // Reference model state: pixel index within the current video packet.
    bit m_video = 1'b0;
    int m_p, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic beat_t mk(input logic s, input logic e, input logic [23:0] d);
        beat_t b;
        b.sop = s; b.eop = e; b.d = d;
        return b;
    endfunction

    function automatic void model_beat(input beat_t b);
        beat_t o = b;
        res_t  r;
        int x, y;
        if (b.sop) begin
            m_video = (b.d[3:0] == 4'd0);
            m_p = 0; m_cnt = 0; m_xmin = W - 1; m_xmax = 0; m_ymin = H - 1; m_ymax = 0;
        end else if (m_video) begin
            x = m_p % W;
            y = (m_p / W > H - 1) ? H - 1 : m_p / W;
            m_p++;
            if (b.d[7:0] >= thr_r_min && b.d[15:8] <= thr_g_max && b.d[23:16] <= thr_b_max) begin
                if (m_cnt < CMAX) m_cnt++;
                if (x < m_xmin) m_xmin = x;
                if (x > m_xmax) m_xmax = x;
                if (y < m_ymin) m_ymin = y;
                if (y > m_ymax) m_ymax = y;
                if (hilite_en) o.d = HL;
            end
            if (b.eop) begin
                r = '0;
                if (m_cnt != 0) begin
                    r.xmin = 11'(m_xmin); r.xmax = 11'(m_xmax);
                    r.ymin = 10'(m_ymin); r.ymax = 10'(m_ymax); r.cnt = 19'(m_cnt);
                end
                res_q.push_back(r);
                m_video = 1'b0;
            end
        end
        exp_q.push_back(o);
    endfunction

    function automatic logic [23:0] pix(input int mode, input int p);
        int x = p % W;
        int y = p / W;
        logic [31:0] r = $urandom;
        case (mode)
            0: return 24'h000000;
            1: if (x >= 3 && x <= 8 && y >= 2 && y <= 5) return 24'h0000FF;
               else return {r[23:16] | 8'h80, r[15:8] | 8'h80, r[7:0]};
            2: return (p == W * H - 1) ? 24'h0000FF : 24'h000000;
            default: return r[23:0];
        endcase
    endfunction

    function automatic void add_video(input int mode, input int npix, input bit with_eop);
        logic [31:0] r = $urandom;
        stim_q.push_back(mk(1'b1, 1'b0, {r[23:4], 4'h0}));
        for (int p = 0; p < npix; p++)
            stim_q.push_back(mk(1'b0, with_eop && (p == npix - 1), pix(mode, p)));
    endfunction

    function automatic void add_ctrl();
        logic [31:0] r = $urandom;
        stim_q.push_back(mk(1'b1, 1'b0, {r[23:4], 4'hF}));
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(1'b0, i == 2, 24'($urandom)));
    endfunction

    function automatic void add_loose(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(mk(1'b0, i == n - 1, 24'($urandom)));
    endfunction

    task automatic run_stim(input int gap_pct);
        beat_t b;
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_rdy = in_ready;
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            if (last_rdy && $urandom_range(99) >= gap_pct) begin
                b = stim_q.pop_front();
                in_data = b.d; in_sop = b.sop; in_eop = b.eop; in_valid = 1'b1;
                model_beat(b);
            end else begin
                in_valid = 1'b0;
            end
            last_rdy = in_ready;
            n++;
            if (n > 20000) begin
                check("stim_timeout", 64'(stim_q.size()), 64'd0);
                stim_q.delete();
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || res_q.size() > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check(name, 64'(exp_q.size() + res_q.size()), 64'd0);
    endtask

    task automatic check_box(input string name, input int xmn, input int xmx,
                             input int ymn, input int ymx, input int c);
        check(name, 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, match_count}),
              64'({11'(xmn), 11'(xmx), 10'(ymn), 10'(ymx), 19'(c)}));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_src"}, 64'({out_valid, out_sop, out_eop, out_data}), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_results"}, 64'({result_valid, bbox_x_min, bbox_x_max, bbox_y_min,
                                      bbox_y_max, match_count}), 64'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = bp_mode ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    initial begin
        beat_t e;
        res_t  r;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (in_ready && (D - int'(dut.count_q)) < 2) rdy_viol++;
                if (!out_valid && exp_q.size() > 0) bubbles++;
                if (out_valid) begin
                    out_total++;
                    if (exp_q.size() == 0) begin
                        check("beat_extra", 64'({out_sop, out_eop, out_data}), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({out_sop, out_eop, out_data}), 64'(e));
                    end
                    if (!out_sop && out_data == HL) hl_total++;
                    if (out_eop) last_eop_cyc = cyc;
                end
                if (result_valid) begin
                    if (res_q.size() == 0) begin
                        check("result_extra", 64'(match_count), 64'hDEAD_0000_0000_0000);
                    end else begin
                        r = res_q.pop_front();
                        check("result", 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
                                             match_count}), 64'(r));
                    end
                    if (tight) check("result_latency", 64'(cyc - last_eop_cyc), 64'd1);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, o0, h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;

        // Control packet then an all-black frame, full throughput.
        tight = 1'b1;
        add_ctrl();
        add_video(0, W * H, 1'b1);
        b0 = bubbles; o0 = out_total;
        run_stim(0);
        drain("t1_drain");
        check("t1_bubbles", 64'(bubbles - b0), 64'd1);
        check("t1_beats", 64'(out_total - o0), 64'(5 + W * H));
        check_box("t1_box", 0, 0, 0, 0, 0);

        // Red rectangle on a non-matching background.
        add_video(1, W * H, 1'b1);
        run_stim(0);
        drain("t2_drain");
        check_box("t2_box", 3, 8, 2, 5, 24);

        // Same frame recoloured.
        hilite_en = 1'b1;
        h0 = hl_total;
        add_video(1, W * H, 1'b1);
        run_stim(0);
        drain("t3_drain");
        check("t3_hilite_pixels", 64'(hl_total - h0), 64'd24);
        hilite_en = 1'b0;

        // Single match on the final (eop) pixel.
        add_video(2, W * H, 1'b1);
        run_stim(0);
        drain("t4_drain");
        check_box("t4_box", W - 1, W - 1, H - 1, H - 1, 1);

        // Backpressure and upstream gaps.
        tight = 1'b0;
        bp_mode = 1'b1;
        add_video(1, W * H, 1'b1);
        run_stim(30);
        drain("t5_drain");
        check_box("t5_box", 3, 8, 2, 5, 24);

        // Random pixels and random thresholds.
        for (int f = 0; f < 2; f++) begin
            thr_r_min = 8'($urandom); thr_g_max = 8'($urandom); thr_b_max = 8'($urandom);
            hilite_en = 1'($urandom_range(1));
            add_video(3, W * H, 1'b1);
            run_stim(20);
            drain("t6_drain");
        end
        thr_r_min = 8'd128; thr_g_max = 8'd64; thr_b_max = 8'd64; hilite_en = 1'b0;

        // Aborted frames, stray beats in IDLE, then a full frame.
        add_video(1, 50, 1'b0);
        add_video(1, W * H, 1'b1);
        add_video(3, 30, 1'b0);
        add_ctrl();
        add_loose(3);
        run_stim(10);
        drain("t7_drain");
        check_box("t7_box", 3, 8, 2, 5, 24);

        // Over-long frame where every pixel matches: y must saturate.
        thr_r_min = 8'd0; thr_g_max = 8'd255; thr_b_max = 8'd255;
        add_video(3, W * H + W + 3, 1'b1);
        run_stim(10);
        drain("t7b_drain");
        check_box("t7b_box", 0, W - 1, 0, H - 1, W * H + W + 3);
        thr_r_min = 8'd128; thr_g_max = 8'd64; thr_b_max = 8'd64;

        // Reset in the middle of a frame, then a clean frame.
        add_video(1, 100, 1'b0);
        run_stim(0);
        check("ovf_before_reset", 64'(dut.ovf_q), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_q.delete();
        res_q.delete();
        m_video = 1'b0;
        last_rdy = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        bp_mode = 1'b0;
        tight = 1'b1;
        add_video(1, W * H, 1'b1);
        run_stim(0);
        drain("t8_drain");
        check_box("t8_box", 3, 8, 2, 5, 24);

        check("in_ready_rule", 64'(rdy_viol), 64'd0);
        check("ovf_end", 64'(dut.ovf_q), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
